// File: rtl/uart_cmd_ctrl.sv
// Packet-framed command sequencer between uart_rx/uart_tx and the camera config register port.
// Optional inter-byte timeout is compiled in when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl #(
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter logic [15:0] TIMEOUT_MAX = 16'd21700,
   parameter logic [7:0]  ACK_BYTE    = 8'h06,
   parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       reg_wr_req,
   output logic       reg_rd_req,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   input  logic       reg_ack,
   input  logic [7:0] reg_rdata,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic [7:0] err_cnt
);

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_SUM,
      S_EXEC,
      S_RESP
   } state_t;

   state_t     state;
   logic       rx_prev;
   logic       byte_ev;
   logic [7:0] cmd_byte;
   logic [7:0] sum_calc;
   logic [7:0] err_next;
   logic       parsing;
   logic       tmo_hit;

   // one event per strobe, however long rx_ready stays high
   assign byte_ev  = rx_ready & ~rx_prev;
   assign sum_calc = cmd_byte + reg_addr + reg_wdata;
   assign err_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
   assign parsing  = (state == S_CMD) || (state == S_ADDR) ||
                     (state == S_DATA) || (state == S_SUM);

`ifdef UART_CMD_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst || byte_ev || !parsing) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   assign tmo_hit = parsing && !byte_ev && (tmo_cnt == TIMEOUT_MAX);
`else
   // without the timeout the parser waits forever; TIMEOUT_MAX is kept only for a uniform parameter list
   assign tmo_hit = 1'b0 & (TIMEOUT_MAX != 16'd0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         rx_prev    <= 1'b0;
         cmd_byte   <= '0;
         reg_wr_req <= 1'b0;
         reg_rd_req <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         err_cnt    <= '0;
      end else begin
         rx_prev  <= rx_ready;
         tx_start <= 1'b0;

         if (tmo_hit) begin
            state   <= S_IDLE;
            err_cnt <= err_next;
         end else begin
            case (state)
               S_IDLE: begin
                  if (byte_ev && (rx_data == SYNC_BYTE)) begin
                     state <= S_CMD;
                  end
               end

               S_CMD: begin
                  if (byte_ev) begin
                     cmd_byte <= rx_data;
                     state    <= S_ADDR;
                  end
               end

               S_ADDR: begin
                  if (byte_ev) begin
                     reg_addr <= rx_data;
                     state    <= S_DATA;
                  end
               end

               S_DATA: begin
                  if (byte_ev) begin
                     reg_wdata <= rx_data;
                     state     <= S_SUM;
                  end
               end

               S_SUM: begin
                  if (byte_ev) begin
                     if (rx_data != sum_calc) begin
                        tx_data <= NAK_BYTE;
                        err_cnt <= err_next;
                        state   <= S_RESP;
                     end else if (cmd_byte == CMD_WRITE) begin
                        reg_wr_req <= 1'b1;
                        state      <= S_EXEC;
                     end else if (cmd_byte == CMD_READ) begin
                        reg_rd_req <= 1'b1;
                        state      <= S_EXEC;
                     end else begin
                        tx_data <= NAK_BYTE;
                        err_cnt <= err_next;
                        state   <= S_RESP;
                     end
                  end
               end

               S_EXEC: begin
                  if (reg_ack) begin
                     reg_wr_req <= 1'b0;
                     reg_rd_req <= 1'b0;
                     tx_data    <= reg_wr_req ? ACK_BYTE : reg_rdata;
                     state      <= S_RESP;
                  end
               end

               S_RESP: begin
                  if (!tx_busy) begin
                     tx_start <= 1'b1;
                     state    <= S_IDLE;
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
